// File: rtl/alu4_pkg.sv
// alu4_pkg: opcode encodings and default operand width shared by the ALU and its bench.
package alu4_pkg;

  localparam int ALU4_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SLT = 3'b110,
    OP_SLL = 3'b111
  } alu4_op_e;

endpackage

// File: rtl/alu4_addsub.sv
// alu4_addsub: shared adder for ADD, SUB and SLT.
// sub=1 computes a + ~b + ~cin, so cout=1 means "no borrow".
module alu4_addsub
  import alu4_pkg::*;
#(
  parameter int WIDTH = ALU4_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   full;

  // Invert b and carry-in for subtraction, then one WIDTH+1 bit add.
  always_comb begin
    b_eff = sub ? ~b : b;
    c_eff = sub ? ~cin : cin;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    sum   = full[WIDTH-1:0];
    cout  = full[WIDTH];
    // Same-sign addends with a differently-signed sum; against the
    // effective b this covers both the ADD and SUB overflow rules.
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_4bit.sv
// alu_4bit: registered ALU, one-cycle latency, synchronous active-high reset.
// Optional feature: define ALU4_STICKY_OVF_EN to add the ovf_sticky output.
module alu_4bit
  import alu4_pkg::*;
#(
  parameter int WIDTH = ALU4_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             out_valid
`ifdef ALU4_STICKY_OVF_EN
  ,
  output logic             ovf_sticky
`endif
);

  alu4_op_e op;
  logic     as_sub;
  logic     as_cin;
  logic [WIDTH-1:0] as_sum;
  logic     as_cout;
  logic     as_ovf;

  logic [WIDTH-1:0] op_res;
  logic     op_cout;
  logic     op_ovf;

  logic [WIDTH-1:0] result_d, result_q;
  logic     cout_d, cout_q;
  logic     zero_d, zero_q;
  logic     negative_d, negative_q;
  logic     overflow_d, overflow_q;
  logic     out_valid_d, out_valid_q;

  // Adder control: SLT is a subtract with no borrow-in, whatever cin says.
  always_comb begin
    op     = alu4_op_e'(opcode);
    as_sub = (op == OP_SUB) || (op == OP_SLT);
    as_cin = (op == OP_SLT) ? 1'b0 : cin;
  end

  alu4_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .b    (b),
    .cin  (as_cin),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  // Per-opcode result and carry/overflow before registering.
  always_comb begin
    op_res  = '0;
    op_cout = 1'b0;
    op_ovf  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        op_res  = as_sum;
        op_cout = as_cout;
        op_ovf  = as_ovf;
      end
      OP_AND: op_res = a & b;
      OP_OR:  op_res = a | b;
      OP_XOR: op_res = a ^ b;
      OP_NOT: op_res = ~a;
      // Signed less-than: sign of a-b, corrected when the subtract overflowed.
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      OP_SLL: begin
        op_res  = {a[WIDTH-2:0], 1'b0};
        op_cout = a[WIDTH-1];
      end
      default: op_res = '0;
    endcase
  end

  // Next state: reset wins, accepted ops update, otherwise hold.
  always_comb begin
    result_d    = result_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (rst) begin
      result_d   = '0;
      cout_d     = 1'b0;
      zero_d     = 1'b1;
      negative_d = 1'b0;
      overflow_d = 1'b0;
    end else if (in_valid) begin
      result_d    = op_res;
      cout_d      = op_cout;
      zero_d      = (op_res == '0);
      negative_d  = op_res[WIDTH-1];
      overflow_d  = op_ovf;
      out_valid_d = 1'b1;
    end
  end

  // Output registers; reset values come through the _d path.
  always_ff @(posedge clk) begin
    result_q    <= result_d;
    cout_q      <= cout_d;
    zero_q      <= zero_d;
    negative_q  <= negative_d;
    overflow_q  <= overflow_d;
    out_valid_q <= out_valid_d;
  end

  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

`ifdef ALU4_STICKY_OVF_EN
  logic ovf_sticky_d, ovf_sticky_q;

  // Sticky overflow: sets on any accepted overflowing op, clears only on reset.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (rst)
      ovf_sticky_d = 1'b0;
    else if (in_valid && op_ovf)
      ovf_sticky_d = 1'b1;
  end

  // Sticky overflow register.
  always_ff @(posedge clk) begin
    ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed vectors with hand-computed results for alu_4bit (default build).
module tb_alu_4bit;
  import alu4_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;
  logic [2:0] opcode;
  logic       cin;
  logic [3:0] result;
  logic       cout, zero, negative, overflow, out_valid;

  int n_chk = 0;
  int n_err = 0;

  alu_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .cin       (cin),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Present one op for one edge, then check result, flags {cout,zero,neg,ovf} and out_valid.
  task automatic run_op(input string tag, input logic [2:0] opc, input logic [3:0] va,
                        input logic [3:0] vb, input logic vc,
                        input logic [3:0] exp_res, input logic [3:0] exp_flags);
    opcode = opc; a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " res"},   32'(result), 32'(exp_res));
    chk({tag, " flags"}, 32'({cout, zero, negative, overflow}), 32'(exp_flags));
    chk({tag, " vld"},   32'(out_valid), 32'd1);
  endtask

  initial begin
    // Reset with a live op presented: op must be discarded.
    rst = 1'b1; in_valid = 1'b1; opcode = OP_ADD; a = 4'b0111; b = 4'b0111; cin = 1'b0;
    @(posedge clk); #1;
    chk("rst res",   32'(result), 32'h0);
    chk("rst flags", 32'({cout, zero, negative, overflow}), 32'b0100);
    chk("rst vld",   32'(out_valid), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle vld", 32'(out_valid), 32'd0);

    //        tag          opcode  a        b        cin   result   {c,z,n,v}
    run_op("add 7+7",     OP_ADD, 4'b0111, 4'b0111, 1'b0, 4'b1110, 4'b0011);
    run_op("add 8+8",     OP_ADD, 4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b1101);
    run_op("add F+1",     OP_ADD, 4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b1100);
    run_op("add 3+4+c",   OP_ADD, 4'b0011, 4'b0100, 1'b1, 4'b1000, 4'b0011);
    run_op("sub 2-4",     OP_SUB, 4'b0010, 4'b0100, 1'b0, 4'b1110, 4'b0010);
    run_op("sub 8-1",     OP_SUB, 4'b1000, 4'b0001, 1'b0, 4'b0111, 4'b1001);
    run_op("sub 5-3-b",   OP_SUB, 4'b0101, 4'b0011, 1'b1, 4'b0001, 4'b1000);
    run_op("slt 8,1",     OP_SLT, 4'b1000, 4'b0001, 1'b0, 4'b0001, 4'b0000);
    run_op("slt 1,8",     OP_SLT, 4'b0001, 4'b1000, 1'b0, 4'b0000, 4'b0100);
    run_op("slt 3,3 c",   OP_SLT, 4'b0011, 4'b0011, 1'b1, 4'b0000, 4'b0100);
    run_op("slt 7,8",     OP_SLT, 4'b0111, 4'b1000, 1'b0, 4'b0000, 4'b0100);
    run_op("sll 8",       OP_SLL, 4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b1100);
    run_op("sll 5",       OP_SLL, 4'b0101, 4'b0000, 1'b1, 4'b1010, 4'b0010);
    run_op("and",         OP_AND, 4'b1010, 4'b1100, 1'b1, 4'b1000, 4'b0010);
    run_op("or",          OP_OR,  4'b1010, 4'b0101, 1'b0, 4'b1111, 4'b0010);
    run_op("xor",         OP_XOR, 4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0100);
    run_op("not",         OP_NOT, 4'b0000, 4'b1010, 1'b0, 4'b1111, 4'b0010);

    // in_valid low: outputs hold the NOT result, out_valid drops after one cycle.
    opcode = OP_ADD; a = 4'b0001; b = 4'b0001; cin = 1'b0;
    @(posedge clk); #1;
    chk("hold res",   32'(result), 32'hF);
    chk("hold flags", 32'({cout, zero, negative, overflow}), 32'b0010);
    chk("hold vld",   32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("hold2 res",  32'(result), 32'hF);

    // Overflowing op set up, then reset with in_valid high takes priority.
    run_op("add pre-rst", OP_ADD, 4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b0011);
    rst = 1'b1; in_valid = 1'b1; opcode = OP_OR; a = 4'b1111; b = 4'b1111;
    @(posedge clk); #1;
    chk("rst2 res",   32'(result), 32'h0);
    chk("rst2 flags", 32'({cout, zero, negative, overflow}), 32'b0100);
    chk("rst2 vld",   32'(out_valid), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    run_op("add post-rst", OP_ADD, 4'b0001, 4'b0010, 1'b0, 4'b0011, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
ALU_4BIT -- requirements
Module: alu_4bit

Interface
- REQ-001: Parameter WIDTH, default 4, operand/result width; all requirements below are stated for WIDTH=4 and SHALL generalise to any WIDTH >= 2.
- REQ-002: The module SHALL use one clock; reset is synchronous and active-high.
- REQ-003: clk  input  1  rising-edge clock for all state.
- REQ-004: rst  input  1  synchronous active-high reset.
- REQ-005: in_valid  input  1  operands/opcode sampled this cycle when high.
- REQ-006: a  input  WIDTH  operand A (two's complement where signed).
- REQ-007: b  input  WIDTH  operand B.
- REQ-008: opcode  input  3  operation select.
- REQ-009: cin  input  1  carry-in (ADD) / borrow-in (SUB); ignored otherwise.
- REQ-010: result  output  WIDTH  registered result.
- REQ-011: cout  output  1  registered carry/shift-out flag.
- REQ-012: zero  output  1  registered, high when result is all zeros.
- REQ-013: negative  output  1  registered copy of result MSB.
- REQ-014: overflow  output  1  registered signed-overflow flag.
- REQ-015: out_valid  output  1  high for one cycle when outputs were updated from an accepted operation.

Function
- REQ-016: Opcodes: 000 ADD a+b+cin; 001 SUB a-b-cin; 010 AND; 011 OR; 100 XOR; 101 NOT ~a; 110 SLT signed (result = 1 if $signed(a) < $signed(b), else 0); 111 SLL a<<1, LSB filled with 0.
- REQ-017: Latency SHALL be exactly one cycle: operation accepted on edge N (in_valid=1) appears on outputs with out_valid=1 after edge N.
- REQ-018: When in_valid=0, result/cout/zero/negative/overflow SHALL hold their previous values and out_valid SHALL be 0.
- REQ-019: ADD: cout = bit WIDTH of a+b+cin; overflow = 1 when a and b have equal sign and result sign differs.
- REQ-020: SUB SHALL compute a + ~b + ~cin; cout = carry out of that sum (1 = no borrow); overflow = 1 when a and b differ in sign and result sign differs from a.
- REQ-021: SLL: cout = a[WIDTH-1]; overflow = 0.
- REQ-022: AND, OR, XOR, NOT, SLT: cout = 0, overflow = 0.
- REQ-023: zero and negative SHALL be derived from the result of every opcode, including SLT.
- REQ-024: Wrap-around: results SHALL be truncated modulo 2^WIDTH (1111+0001 -> 0000, cout=1).

Reset
- REQ-025: While rst=1 at a clock edge, result=0, cout=0, negative=0, overflow=0, out_valid=0, zero=1.
- REQ-026: rst SHALL take priority over in_valid; an operation presented in the reset cycle SHALL be discarded.

Configuration
- REQ-027: With macro ALU4_STICKY_OVF_EN defined, an extra output ovf_sticky (1 bit) SHALL set on any accepted operation producing overflow=1 and clear only on reset; without the macro the port and its logic SHALL be absent.

Structure
- REQ-028: Package alu4_pkg SHALL hold the opcode constants (OP_ADD..OP_SLL) and default WIDTH.
- REQ-029: One sub-module alu4_addsub SHALL implement the shared adder (sum, carry, overflow) used by ADD, SUB and SLT.

Verification
- REQ-030: ADD a=0111 b=0111 cin=0 -> result=1110, cout=0, negative=1, overflow=1, zero=0.
- REQ-031: ADD a=1000 b=1000 cin=0 -> result=0000, cout=1, zero=1, overflow=1; ADD 1111+0001 -> 0000, cout=1, overflow=0.
- REQ-032: SUB a=0010 b=0100 cin=0 -> result=1110, cout=0, negative=1, overflow=0; SUB 1000-0001 -> 0111, cout=1, overflow=1.
- REQ-033: SLT 1000,0001 -> 0001; SLT 0001,1000 -> 0000 with zero=1; SLL 1000 -> 0000, cout=1, zero=1.
- REQ-034: Logic: AND 1010,1100 -> 1000; OR 1010,0101 -> 1111 negative=1; XOR 1111,1111 -> 0000 zero=1; NOT 0000 -> 1111.
- REQ-035: Timing/reset: in_valid pulse -> out_valid one cycle later only; in_valid=0 holds outputs; rst asserted with in_valid=1 -> reset values, out_valid=0.
